// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receive and transmit blocks.
//
// The state encodings are fixed 3-bit values so that debug probes and the
// uart_tx sibling decode the same numbers for the same states.
package uart_pkg;

  localparam int UART_STATE_W = 3;

  typedef enum logic [UART_STATE_W-1:0] {
    UART_IDLE      = 3'd0,
    UART_START     = 3'd1,
    UART_DATA      = 3'd2,
    UART_STOP      = 3'd3,
    UART_WAIT_HIGH = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period down-counter for the UART state machines.
//
// Ports
//   clk      : clock
//   rst      : asynchronous active-high reset, clears the count
//   load     : load strobe, takes priority over counting
//   load_val : value loaded when load is high
//   zero     : high while the count is zero (the owning FSM samples then)
//
// The count holds at zero instead of wrapping, so an idle counter stays
// parked at zero until the next load.
module uart_bit_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_stream.sv
// uart_rx_stream: UART receiver with an AXI-Stream style byte output.
//
// Ports
//   clk           : single clock for all logic
//   rst           : asynchronous active-high reset
//   rxd           : serial line (already synchronised to clk), idle high
//   prescale      : clk cycles per bit, captured at each start-bit edge
//   m_axis_tdata  : received data word
//   m_axis_tvalid : tdata holds a word not yet accepted
//   m_axis_tready : consumer accepts the word
//   busy          : high whenever the receiver is not idle
//   frame_error   : one-cycle pulse when the stop bit samples low
//   overrun_error : one-cycle pulse when a word is dropped because the
//                   output register is still full
//
// Frame timing: the first low cycle seen in IDLE starts the frame. The
// start bit is sampled half a bit later, and every further bit one full bit
// after the previous sample, so each bit is sampled near its centre. The
// output is a single register stage; there is no buffering beyond it.
module uart_rx_stream #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxd,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      busy,
  output logic                      frame_error,
  output logic                      overrun_error
);

  import uart_pkg::*;

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  // Below two cycles per bit the half-bit delay would be zero cycles.
  localparam logic [PRESCALE_WIDTH-1:0] MIN_EFF = PRESCALE_WIDTH'(2);

  uart_state_e state_q, state_d;

  logic [PRESCALE_WIDTH-1:0] eff_in;
  logic [PRESCALE_WIDTH-1:0] eff_q;
  logic [PRESCALE_WIDTH-1:0] half_load;
  logic [PRESCALE_WIDTH-1:0] full_load;
  logic [PRESCALE_WIDTH-1:0] timer_val;
  logic                      timer_load;
  logic                      bit_zero;

  logic                      frame_start;
  logic                      data_start;
  logic                      data_sample;
  logic                      deliver;
  logic                      stop_bad;

  logic [IDX_W-1:0]          idx_q;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic [DATA_WIDTH:0]       shift_ext;

  // The period is taken from the live input only when a frame starts; the
  // rest of the frame uses the captured copy, so prescale may change freely
  // while a frame is in flight.
  assign eff_in    = (prescale < MIN_EFF) ? MIN_EFF : prescale;
  assign half_load = (eff_in >> 1) - 1'b1;
  assign full_load = eff_q - 1'b1;

  // New bit enters at the top; after DATA_WIDTH shifts the first bit
  // received sits in bit 0 (LSB first on the wire).
  assign shift_ext = {rxd, shift_q};

  assign busy = (state_q != UART_IDLE);

  uart_bit_timer #(
    .WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (bit_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UART_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_load  = 1'b0;
    timer_val   = full_load;
    frame_start = 1'b0;
    data_start  = 1'b0;
    data_sample = 1'b0;
    deliver     = 1'b0;
    stop_bad    = 1'b0;

    case (state_q)
      UART_IDLE: begin
        if (!rxd) begin
          frame_start = 1'b1;
          timer_load  = 1'b1;
          timer_val   = half_load;
          state_d     = UART_START;
        end
      end

      UART_START: begin
        if (bit_zero) begin
          if (rxd) begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = UART_IDLE;
          end else begin
            timer_load = 1'b1;
            data_start = 1'b1;
            state_d    = UART_DATA;
          end
        end
      end

      UART_DATA: begin
        if (bit_zero) begin
          // The reload on the last data bit times the stop bit.
          data_sample = 1'b1;
          timer_load  = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = UART_STOP;
          end
        end
      end

      UART_STOP: begin
        if (bit_zero) begin
          if (rxd) begin
            deliver = 1'b1;
            state_d = UART_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = UART_WAIT_HIGH;
          end
        end
      end

      UART_WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for new start bits.
        if (rxd) begin
          state_d = UART_IDLE;
        end
      end

      default: begin
        state_d = UART_IDLE;
      end
    endcase
  end

  // Frame capture: bit period, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eff_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      if (frame_start) begin
        eff_q <= eff_in;
      end
      if (data_start) begin
        idx_q <= '0;
      end
      if (data_sample) begin
        shift_q <= shift_ext[DATA_WIDTH:1];
        idx_q   <= idx_q + 1'b1;
      end
    end
  end

  // Output stage: one register. A word arriving while the previous one is
  // still held and not being taken this cycle is dropped, keeping tdata
  // stable for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      frame_error   <= stop_bad;
      overrun_error <= 1'b0;
      if (deliver) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tdata  <= shift_q;
          m_axis_tvalid <= 1'b1;
        end else begin
          overrun_error <= 1'b1;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_stream.md
UART_RX_STREAM -- requirements
Module: uart_rx_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 16, width of the prescale input.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic (125 MHz in the system).
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port rxd, input, 1, serial line, already synchronised to clk upstream, idle high.
REQ-006 SHALL have port prescale, input, PRESCALE_WIDTH, clk cycles per bit (1085 for 115200 bps at 125 MHz).
REQ-007 SHALL have port m_axis_tdata, output, DATA_WIDTH, received byte.
REQ-008 SHALL have port m_axis_tvalid, output, 1, tdata holds an unconsumed byte.
REQ-009 SHALL have port m_axis_tready, input, 1, consumer accepts the byte.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port frame_error, output, 1, one-cycle pulse when the stop bit samples 0.
REQ-012 SHALL have port overrun_error, output, 1, one-cycle pulse when a byte is dropped.

Function
REQ-013 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 SHALL use a down-counter bit_cnt; a state "samples" on the cycle bit_cnt==0, otherwise bit_cnt decrements.
REQ-015 IDLE: on rxd==0, SHALL latch eff = max(prescale,2), load bit_cnt=(eff>>1)-1, and go to START.
REQ-016 prescale changes while not in IDLE SHALL be ignored until the next frame.
REQ-017 START sample with rxd==1 (glitch) SHALL return to IDLE with no output and no error.
REQ-018 START sample with rxd==0 SHALL load bit_cnt=eff-1, clear the data index, and go to DATA.
REQ-019 DATA SHALL shift rxd in LSB first at each sample and reload bit_cnt=eff-1; after DATA_WIDTH samples it SHALL go to STOP.
REQ-020 STOP sample with rxd==1 SHALL deliver the byte and go to IDLE.
REQ-021 STOP sample with rxd==0 SHALL pulse frame_error, discard the byte, and go to WAIT_HIGH.
REQ-022 WAIT_HIGH SHALL go to IDLE on the first cycle rxd==1 (break conditions do not retrigger).
REQ-023 Delivery SHALL assert m_axis_tvalid and update tdata on the cycle after the stop sample.
REQ-024 Delivery latency SHALL be eff>>1 + (DATA_WIDTH+1)*eff + 1 cycles from the first rxd-low cycle seen in IDLE.
REQ-025 Handshake: a transfer occurs when tvalid&&tready; tvalid SHALL then clear unless a new byte is delivered in the same cycle.
REQ-026 tdata SHALL be stable while tvalid is high and tready is low.
REQ-027 Delivery while tvalid&&!tready SHALL keep the old tdata, drop the new byte, and pulse overrun_error.
REQ-028 Delivery coinciding with tvalid&&tready SHALL load the new byte and keep tvalid high, with no error.
REQ-029 Output SHALL be a single register stage; there SHALL be no FIFO.

Reset
REQ-030 rst SHALL immediately force state IDLE; bit_cnt, shift register, tdata, tvalid, busy, frame_error and overrun_error SHALL all be 0.
REQ-031 Reset mid-frame SHALL discard the partial byte; the first falling edge after reset release SHALL start a new frame.

Structure
REQ-032 State encodings (3-bit) SHALL live in a shared uart package/header so the uart_tx sibling uses the same constants.
REQ-033 The bit-period down-counter SHALL be the sub-module uart_bit_timer (load value, load strobe, zero flag); all other logic SHALL stay in uart_rx_stream.

Verification
REQ-034 Nominal: prescale=16, send 0x55 with stop=1, tready=1 -> tvalid for 1 cycle with tdata=0x55, 153 cycles after the falling edge; no error pulses.
REQ-035 Glitch: prescale=16, rxd low for 4 cycles then high -> busy returns to 0 after 8 cycles; tvalid and errors stay 0.
REQ-036 Framing: send 0xA3 with stop=0 and hold rxd low 40 cycles -> frame_error pulses once, tvalid stays 0, busy stays high until rxd rises, then the next 0x3C is received correctly.
REQ-037 Overrun: tready=0, send 0x11 then 0x22 -> tdata=0x11 held, overrun_error pulses once at the 0x22 stop; raising tready -> 0x11 transfers and tvalid drops.
REQ-038 Back-to-back: tready pulsed on the same cycle as the 0x22 delivery -> 0x11 transfers, tdata=0x22, tvalid stays high, no overrun.
REQ-039 Reset mid-DATA: assert rst after 3 data bits of 0xFF -> all outputs 0 the same cycle; after release, 0x81 is received correctly.
